seq_detect_p: RTL and testbench
===============================

SEQ_DETECT_P -- requirements
Module: seq_detect_p

Interface
REQ-001 Parameter PAT_LEN, default 4: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, PAT_LEN bits wide: target sequence; PATTERN[PAT_LEN-1] is the first bit expected on the line.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = the detector restarts empty after every match.
REQ-004 Parameter CNT_W, default 8: width of the match counter; legal range 1..32.
REQ-005 Port clk  input  1  system clock; all sequential logic on the rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port x  input  1  serial data bit, sampled on a rising clk edge only when en=1.
REQ-008 Port en  input  1  sample enable; en=0 holds all state, and F drops to 0.
REQ-009 Port clr  input  1  synchronous clear of history, fill count, F and match_cnt.
REQ-010 Port F  output  1  registered one-cycle match pulse.
REQ-011 Port match_cnt  output  CNT_W  saturating count of matches since reset or clr.

Function
REQ-012 Shift register hist[PAT_LEN-1:0]: on each sampled edge, hist <= {hist[PAT_LEN-2:0], x}; the newest bit goes into the LSB.
REQ-013 Fill counter fill, 0..PAT_LEN, increments on each sampled edge and saturates at PAT_LEN.
REQ-014 Match condition, evaluated combinationally from pre-edge state: en=1, clr=0, the updated fill equals PAT_LEN, and the updated hist equals PATTERN.
REQ-015 F is registered: F=1 for exactly the one cycle that follows the edge on which the final pattern bit is sampled; otherwise F=0.
REQ-016 Latency: the last pattern bit is present at edge k; F is high from edge k until edge k+1.
REQ-017 OVERLAP=1: on a match, hist and fill update normally, so a suffix of the pattern can start the next match.
REQ-018 OVERLAP=0: on a match, fill <= 0, so the next match needs PAT_LEN fresh sampled bits. hist still shifts.
REQ-019 On a match, match_cnt increments by 1 on the same edge that sets F; at 2^CNT_W-1 it holds and does not wrap.
REQ-020 en=0 at an edge: hist, fill and match_cnt hold; F <= 0.
REQ-021 clr=1 at an edge (priority over en): hist <= 0, fill <= 0, F <= 0, match_cnt <= 0. A bit presented with clr=1 is discarded and is not sampled.
REQ-022 Back-to-back matches with OVERLAP=1: F stays high on consecutive cycles, and match_cnt increments on every matching edge.
REQ-023 No match is possible before PAT_LEN bits have been sampled since reset, clr or (when OVERLAP=0) the last match. An all-zero PATTERN does not match on the reset history.

Reset
REQ-024 rst=1 asynchronously forces hist=0, fill=0, F=0 and match_cnt=0, with no clock needed.
REQ-025 Reset asserted mid-sequence discards the partial match. After rst drops, the first sampled bit is treated as bit 1 of a new sequence.
REQ-026 Release of rst at any point in the clk period leaves every output at 0 until the first qualifying match.

Verification
REQ-027 Overlap detect (defaults, en=1): x = 1,0,1,1,0,1,1 -> F pulses after bit 4 and after bit 7; match_cnt=2.
REQ-028 Non-overlap (OVERLAP=0): same stream -> F pulses after bit 4 only; match_cnt=1. Appending 0,1,1 -> F pulses after bit 10; match_cnt=2.
REQ-029 Enable gaps: bits 1,0,1,1 with en=0 for 3 cycles between bits 2 and 3 -> F pulses once after bit 4; F=0 throughout the gap.
REQ-030 Reset mid-sequence: sample 1,0,1, pulse rst for 10 ns, then sample 1 -> no F. Then sample 0,1,1 -> F pulses; match_cnt=1.
REQ-031 Saturation (CNT_W=2): 5 overlapping matches -> match_cnt steps 1,2,3,3,3 and F pulses all 5 times. clr=1 for one edge -> match_cnt=0 and F=0.
REQ-032 Long pattern (PAT_LEN=8, PATTERN=8'hA5): shift in 8'hA5 MSB first -> a single F pulse after bit 8. A stream of 8'hA4 -> no F.

Source files
------------

// File: rtl/seq_detect_p.sv
// Serial pattern detector: shifts x into a history register and emits a registered
// one-cycle pulse F plus a saturating match count whenever the last PAT_LEN sampled bits equal PATTERN.
module seq_detect_p #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             clr,
  output logic             F,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               f_q, f_d;
  logic               match;

  // Match is judged on the post-shift view so the pulse lands one edge after the final bit.
  always_comb begin
    hist_shift = {hist_q[PAT_LEN-2:0], x};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match      = en & ~clr & (fill_inc == FILL_FULL) & (hist_shift == PATTERN);
    hist_d     = hist_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    f_d        = 1'b0;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (en) begin
      hist_d = hist_shift;
      f_d    = match;
      if (match && !OVERLAP) begin
        fill_d = '0;
      end else begin
        fill_d = fill_inc;
      end
      if (match && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
    end
  end

  assign F         = f_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_p.sv
// Directed self-checking bench for seq_detect_p; several parameterisations share one stimulus stream.
module tb_seq_detect_p;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x   = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;

  logic       a_f, b_f, c_f, d_f, e_f;
  logic [7:0] a_cnt, b_cnt, d_cnt, e_cnt;
  logic [1:0] c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0]  s1;
  logic [6:0]  s1_fa, s1_fb;
  logic [15:0] s5, s5_fc;
  logic [7:0]  s8;

  always #5 clk = ~clk;

  seq_detect_p u_a (.clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .F(a_f), .match_cnt(a_cnt));
  seq_detect_p #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .F(b_f), .match_cnt(b_cnt));
  seq_detect_p #(.CNT_W(2)) u_c (.clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .F(c_f), .match_cnt(c_cnt));
  seq_detect_p #(.PAT_LEN(8), .PATTERN(8'hA5)) u_d (.clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .F(d_f), .match_cnt(d_cnt));
  seq_detect_p #(.PATTERN(4'b0000)) u_e (.clk(clk), .rst(rst), .x(x), .en(en), .clr(clr), .F(e_f), .match_cnt(e_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic xb, input logic enb);
    @(negedge clk);
    x   = xb;
    en  = enb;
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_step();
    @(negedge clk);
    x   = 1'b1;
    en  = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    s1    = 7'b1011011;
    s1_fa = 7'b0001001;
    s1_fb = 7'b0001000;
    s5    = 16'b1011011011011011;
    s5_fc = 16'b0001001001001001;
    s8    = 8'hA5;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_a_F", 32'(a_f), 32'd0);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_e_F", 32'(e_f), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);
    chk("rst_idle_e_F", 32'(e_f), 32'd0);

    // Overlap versus non-overlap on 1,0,1,1,0,1,1.
    for (int i = 6; i >= 0; i--) begin
      step(s1[i], 1'b1);
      chk("ovl_a_F", 32'(a_f), 32'(s1_fa[i]));
      chk("novl_b_F", 32'(b_f), 32'(s1_fb[i]));
    end
    chk("ovl_a_cnt", 32'(a_cnt), 32'd2);
    chk("novl_b_cnt", 32'(b_cnt), 32'd1);
    step(1'b0, 1'b1);
    chk("novl_b_F8", 32'(b_f), 32'd0);
    step(1'b1, 1'b1);
    chk("novl_b_F9", 32'(b_f), 32'd0);
    step(1'b1, 1'b1);
    chk("novl_b_F10", 32'(b_f), 32'd1);
    chk("novl_b_cnt10", 32'(b_cnt), 32'd2);
    chk("ovl_a_F10", 32'(a_f), 32'd1);
    chk("ovl_a_cnt10", 32'(a_cnt), 32'd3);
    chk("long_d_nomatch", 32'(d_f), 32'd0);

    // Clear with a 1 on x: the bit is discarded.
    clr_step();
    chk("clr_a_cnt", 32'(a_cnt), 32'd0);
    chk("clr_a_F", 32'(a_f), 32'd0);
    chk("clr_b_cnt", 32'(b_cnt), 32'd0);

    // Enable gap with x=1 held during the gap.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("gap_a_F", 32'(a_f), 32'd0);
    end
    step(1'b1, 1'b1);
    chk("gap_a_F3", 32'(a_f), 32'd0);
    step(1'b1, 1'b1);
    chk("gap_a_F4", 32'(a_f), 32'd1);
    chk("gap_a_cnt", 32'(a_cnt), 32'd1);
    step(1'b1, 1'b0);
    chk("en0_drops_F", 32'(a_f), 32'd0);
    chk("en0_holds_cnt", 32'(a_cnt), 32'd1);

    // Reset mid-sequence, released mid-period.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(a_cnt), 32'd0);
    chk("async_rst_F", 32'(a_f), 32'd0);
    #9 rst = 1'b0;
    step(1'b1, 1'b1);
    chk("post_rst_F1", 32'(a_f), 32'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("post_rst_F3", 32'(a_f), 32'd0);
    step(1'b1, 1'b1);
    chk("post_rst_F4", 32'(a_f), 32'd1);
    chk("post_rst_cnt", 32'(a_cnt), 32'd1);

    // Saturation on the 2-bit counter, five overlapping matches.
    clr_step();
    for (int i = 15; i >= 0; i--) begin
      step(s5[i], 1'b1);
      chk("sat_c_F", 32'(c_f), 32'(s5_fc[i]));
      if (i == 12) chk("sat_c_cnt1", 32'(c_cnt), 32'd1);
      if (i == 9)  chk("sat_c_cnt2", 32'(c_cnt), 32'd2);
      if (i == 6)  chk("sat_c_cnt3", 32'(c_cnt), 32'd3);
      if (i == 3)  chk("sat_c_cnt4", 32'(c_cnt), 32'd3);
    end
    chk("sat_c_cnt5", 32'(c_cnt), 32'd3);
    chk("sat_a_cnt", 32'(a_cnt), 32'd5);
    chk("sat_b_cnt", 32'(b_cnt), 32'd3);
    clr_step();
    chk("sat_clr_cnt", 32'(c_cnt), 32'd0);
    chk("sat_clr_F", 32'(c_f), 32'd0);

    // Long pattern: A5 matches once after bit 8, A4 never does.
    for (int i = 7; i >= 0; i--) begin
      step(s8[i], 1'b1);
      chk("long_A5_F", 32'(d_f), (i == 0) ? 32'd1 : 32'd0);
    end
    chk("long_A5_cnt", 32'(d_cnt), 32'd1);
    clr_step();
    s8 = 8'hA4;
    for (int i = 7; i >= 0; i--) begin
      step(s8[i], 1'b1);
      chk("long_A4_F", 32'(d_f), 32'd0);
    end
    chk("long_A4_cnt", 32'(d_cnt), 32'd0);

    // All-zero pattern needs four real samples after clear.
    clr_step();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("zero_pat_early", 32'(e_f), 32'd0);
    end
    step(1'b0, 1'b1);
    chk("zero_pat_F", 32'(e_f), 32'd1);
    chk("zero_pat_cnt", 32'(e_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
